// File: rtl/alu_32_bit_command_sequencer_if.sv
//------------------------------------------------------------------------------
// alu_32_bit_command_sequencer_if
// Purpose : Bundles the command port, the ALU drive/sample port and the response
//           port of the 32-bit ALU command sequencer into one interface.
// Modports:
//   slave  - the sequencer itself (accepts commands, drives the ALU, returns
//            responses).
//   master - the surrounding environment (command source, the ALU and the
//            response sink).
// Signals :
//   Cmd_*   command valid/ready handshake, op code, accumulator select, operands
//   Acc_Clear_In  accumulator clear request (acted on only while idle)
//   ALU_*   enable/op-select/operands towards the ALU, result/carry back from it
//   Rsp_*   response valid/ready handshake, result, carry, zero and error flags
//   Acc_Out current accumulator, Busy_Out high whenever not idle
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface alu_32_bit_command_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Cmd_Valid_In;
    logic                  Cmd_Ready_Out;
    logic [3:0]            Cmd_Op_In;
    logic                  Cmd_Use_Acc_In;
    logic [DATA_WIDTH-1:0] Cmd_Data_A_In;
    logic [DATA_WIDTH-1:0] Cmd_Data_B_In;
    logic                  Acc_Clear_In;

    logic                  ALU_Enable_Out;
    logic [3:0]            ALU_Operation_Select_Out;
    logic [DATA_WIDTH-1:0] ALU_Data_A_Out;
    logic [DATA_WIDTH-1:0] ALU_Data_B_Out;
    logic [DATA_WIDTH-1:0] ALU_Result_In;
    logic                  ALU_Carry_In;

    logic                  Rsp_Valid_Out;
    logic                  Rsp_Ready_In;
    logic [DATA_WIDTH-1:0] Rsp_Result_Out;
    logic                  Rsp_Carry_Out;
    logic                  Rsp_Zero_Out;
    logic                  Rsp_Error_Out;

    logic [DATA_WIDTH-1:0] Acc_Out;
    logic                  Busy_Out;

    modport slave (
        input  Cmd_Valid_In, Cmd_Op_In, Cmd_Use_Acc_In, Cmd_Data_A_In,
               Cmd_Data_B_In, Acc_Clear_In,
        output Cmd_Ready_Out,
        output ALU_Enable_Out, ALU_Operation_Select_Out, ALU_Data_A_Out,
               ALU_Data_B_Out,
        input  ALU_Result_In, ALU_Carry_In,
        output Rsp_Valid_Out, Rsp_Result_Out, Rsp_Carry_Out, Rsp_Zero_Out,
               Rsp_Error_Out,
        input  Rsp_Ready_In,
        output Acc_Out, Busy_Out
    );

    modport master (
        output Cmd_Valid_In, Cmd_Op_In, Cmd_Use_Acc_In, Cmd_Data_A_In,
               Cmd_Data_B_In, Acc_Clear_In,
        input  Cmd_Ready_Out,
        input  ALU_Enable_Out, ALU_Operation_Select_Out, ALU_Data_A_Out,
               ALU_Data_B_Out,
        output ALU_Result_In, ALU_Carry_In,
        input  Rsp_Valid_Out, Rsp_Result_Out, Rsp_Carry_Out, Rsp_Zero_Out,
               Rsp_Error_Out,
        output Rsp_Ready_In,
        input  Acc_Out, Busy_Out
    );
endinterface

// File: rtl/alu_32_bit_command_sequencer.sv
//------------------------------------------------------------------------------
// alu_32_bit_command_sequencer
// Purpose : Initiator side of the 32-bit ALU operation interface. Accepts
//           (op, A, B) commands, drives the ALU for SETTLE_CYCLES cycles,
//           samples result/carry on the last drive cycle and returns them with
//           zero/error flags. A 32-bit accumulator keeps the last result so that
//           commands can chain on it.
// Parameters:
//   DATA_WIDTH     operand/result width (32 to match the ALU)
//   SETTLE_CYCLES  cycles the ALU is enabled before sampling, 1..15
// Ports   :
//   Clock_In    rising-edge clock
//   Reset_n_In  asynchronous active-low reset
//   bus         alu_32_bit_command_sequencer_if.slave (command, ALU, response)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_32_bit_command_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                          Clock_In,
    input  logic                          Reset_n_In,
    alu_32_bit_command_sequencer_if.slave bus
);
    localparam logic [3:0] OP_DIV      = 4'h6;
    localparam logic [3:0] OP_MOD      = 4'h7;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [3:0]            r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_rsp_result;
    logic                  r_rsp_carry;
    logic                  r_rsp_zero;
    logic                  r_rsp_error;
    logic [3:0]            r_settle_cnt;

    logic                  w_cmd_ready;
    logic                  w_alu_enable;
    logic                  w_rsp_valid;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_div_by_zero;
    logic                  w_last_drive;
    logic                  w_acc_clear;
    logic [DATA_WIDTH-1:0] w_op_a;

    // Clear is only acted on while idle; when it coincides with an accept, an
    // accumulator-sourced operand must see the cleared value.
    assign w_acc_clear   = bus.Acc_Clear_In && (r_state == ST_IDLE);
    assign w_op_a        = bus.Cmd_Use_Acc_In ? (w_acc_clear ? '0 : r_acc)
                                              : bus.Cmd_Data_A_In;
    assign w_accept      = bus.Cmd_Valid_In && (r_state == ST_IDLE);
    // Divide/modulo by zero never reaches the ALU; answered directly.
    assign w_div_by_zero = ((bus.Cmd_Op_In == OP_DIV) || (bus.Cmd_Op_In == OP_MOD))
                           && (bus.Cmd_Data_B_In == '0);
    assign w_last_drive  = (r_state == ST_DRIVE) && (r_settle_cnt == SETTLE_LAST);

    // State register
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        w_alu_enable = 1'b0;
        w_rsp_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
                if (bus.Cmd_Valid_In) begin
                    w_state_next = w_div_by_zero ? ST_RESP : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_alu_enable = 1'b1;
                if (w_last_drive) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.Rsp_Ready_In) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: command latch, settle counter, response capture, accumulator
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_error  <= 1'b0;
            r_settle_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_op <= bus.Cmd_Op_In;
                r_a  <= w_op_a;
                r_b  <= bus.Cmd_Data_B_In;
            end

            if (w_accept && w_div_by_zero) begin
                r_rsp_result <= '0;
                r_rsp_carry  <= 1'b0;
                r_rsp_zero   <= 1'b1;
                r_rsp_error  <= 1'b1;
            end else if (w_last_drive) begin
                r_rsp_result <= bus.ALU_Result_In;
                // Ops 0x8-0xF are logical: the ALU carry is meaningless there.
                r_rsp_carry  <= r_op[3] ? 1'b0 : bus.ALU_Carry_In;
                r_rsp_zero   <= (bus.ALU_Result_In == '0);
                r_rsp_error  <= 1'b0;
            end

            if (w_acc_clear) begin
                r_acc <= '0;
            end else if (w_last_drive) begin
                r_acc <= bus.ALU_Result_In;
            end

            if ((r_state == ST_DRIVE) && !w_last_drive) begin
                r_settle_cnt <= r_settle_cnt + 4'd1;
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

    // All ALU-facing outputs come straight from registers, so there is no
    // combinational path from ALU_Result_In/ALU_Carry_In back to the ALU.
    assign bus.Cmd_Ready_Out            = w_cmd_ready;
    assign bus.ALU_Enable_Out           = w_alu_enable;
    assign bus.ALU_Operation_Select_Out = r_op;
    assign bus.ALU_Data_A_Out           = r_a;
    assign bus.ALU_Data_B_Out           = r_b;
    assign bus.Rsp_Valid_Out            = w_rsp_valid;
    assign bus.Rsp_Result_Out           = r_rsp_result;
    assign bus.Rsp_Carry_Out            = r_rsp_carry;
    assign bus.Rsp_Zero_Out             = r_rsp_zero;
    assign bus.Rsp_Error_Out            = r_rsp_error;
    assign bus.Acc_Out                  = r_acc;
    assign bus.Busy_Out                 = w_busy;
endmodule

// File: tb/tb_alu_32_bit_command_sequencer.sv
//------------------------------------------------------------------------------
// tb_alu_32_bit_command_sequencer
// Purpose : Self-checking bench for alu_32_bit_command_sequencer. Emulates the
//           ALU, issues directed and random commands, and compares responses,
//           latency, ALU drive and accumulator against a reference model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_32_bit_command_sequencer;
    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_32_bit_command_sequencer_if #(.DATA_WIDTH(32)) bus ();

    alu_32_bit_command_sequencer #(
        .DATA_WIDTH    (32),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .Clock_In   (clk),
        .Reset_n_In (rst_n),
        .bus        (bus)
    );

    // ALU behaviour: {carry, result}. Logical ops return a junk carry of 1.
    function automatic logic [32:0] alu_fn(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        case (op)
            4'h0: return {1'b0, a} + 33'd1;
            4'h1: return {1'b0, a} - 33'd1;
            4'h2: return {1'b0, a} + {1'b0, b};
            4'h3: return {1'b0, a} - {1'b0, b};
            4'h4: return {a, 1'b0};
            4'h5: begin
                p = 64'(a) * 64'(b);
                return {|p[63:32], p[31:0]};
            end
            4'h6: return (b == 32'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            4'h7: return (b == 32'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a % b};
            4'h8: return {1'b1, a & b};
            4'h9: return {1'b1, a | b};
            4'hA: return {1'b1, ~a};
            4'hB: return {1'b1, a ^ b};
            4'hC: return {1'b1, ~(a & b)};
            4'hD: return {1'b1, ~(a | b)};
            4'hE: return {1'b1, ~(a ^ b)};
            default: return {1'b1, a >> 1};
        endcase
    endfunction

    // The emulated ALU only produces real results while enabled.
    assign {bus.ALU_Carry_In, bus.ALU_Result_In} = bus.ALU_Enable_Out
        ? alu_fn(bus.ALU_Operation_Select_Out, bus.ALU_Data_A_Out, bus.ALU_Data_B_Out)
        : {1'b1, 32'hDEAD_BEEF};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_acc;
    logic [31:0] e_res, e_a, e_b, e_acc;
    logic [3:0]  e_op;
    logic        e_c, e_z, e_e;
    int          e_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check1({tag, "_cmd_ready"}, bus.Cmd_Ready_Out, 1'b1);
        check1({tag, "_alu_en"}, bus.ALU_Enable_Out, 1'b0);
        check({tag, "_alu_op"}, 32'(bus.ALU_Operation_Select_Out), 32'd0);
        check({tag, "_alu_a"}, bus.ALU_Data_A_Out, 32'd0);
        check({tag, "_alu_b"}, bus.ALU_Data_B_Out, 32'd0);
        check1({tag, "_rsp_valid"}, bus.Rsp_Valid_Out, 1'b0);
        check({tag, "_rsp_result"}, bus.Rsp_Result_Out, 32'd0);
        check1({tag, "_rsp_carry"}, bus.Rsp_Carry_Out, 1'b0);
        check1({tag, "_rsp_zero"}, bus.Rsp_Zero_Out, 1'b0);
        check1({tag, "_rsp_error"}, bus.Rsp_Error_Out, 1'b0);
        check({tag, "_acc"}, bus.Acc_Out, 32'd0);
        check1({tag, "_busy"}, bus.Busy_Out, 1'b0);
    endtask

    // Reference model of one command, then present it on the command port.
    task automatic issue(input logic [3:0] op, input logic use_acc,
                         input logic [31:0] a, input logic [31:0] b, input logic clr);
        logic [32:0] r;
        if (clr) m_acc = 32'd0;
        e_op = op;
        e_a  = use_acc ? m_acc : a;
        e_b  = b;
        if ((op == 4'h6 || op == 4'h7) && b == 32'd0) begin
            e_res = 32'd0; e_c = 1'b0; e_z = 1'b1; e_e = 1'b1; e_lat = 1;
        end else begin
            r     = alu_fn(op, e_a, b);
            e_res = r[31:0];
            e_c   = (op < 4'h8) ? r[32] : 1'b0;
            e_z   = (e_res == 32'd0);
            e_e   = 1'b0;
            e_lat = SETTLE + 1;
            m_acc = e_res;
        end
        e_acc = m_acc;
        bus.Cmd_Valid_In   = 1'b1;
        bus.Cmd_Op_In      = op;
        bus.Cmd_Use_Acc_In = use_acc;
        bus.Cmd_Data_A_In  = a;
        bus.Cmd_Data_B_In  = b;
        bus.Acc_Clear_In   = clr;
    endtask

    // Called #1 after an edge with the sequencer idle and a command presented.
    task automatic await_rsp(input string tag);
        int edges = 0;
        bit seen_en = 0;
        bit alu_checked = 0;
        check1({tag, "_accept_ready"}, bus.Cmd_Ready_Out, 1'b1);
        while (bus.Rsp_Valid_Out !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                bus.Cmd_Valid_In = 1'b0;
                bus.Acc_Clear_In = 1'b0;
            end
            if (bus.ALU_Enable_Out === 1'b1) begin
                seen_en = 1;
                if (!alu_checked) begin
                    alu_checked = 1;
                    check({tag, "_alu_op"}, 32'(bus.ALU_Operation_Select_Out), 32'(e_op));
                    check({tag, "_alu_a"}, bus.ALU_Data_A_Out, e_a);
                    check({tag, "_alu_b"}, bus.ALU_Data_B_Out, e_b);
                end
            end
        end
        check({tag, "_latency"}, 32'(edges), 32'(e_lat));
        check1({tag, "_alu_enabled"}, seen_en, !e_e);
        check({tag, "_result"}, bus.Rsp_Result_Out, e_res);
        check1({tag, "_carry"}, bus.Rsp_Carry_Out, e_c);
        check1({tag, "_zero"}, bus.Rsp_Zero_Out, e_z);
        check1({tag, "_error"}, bus.Rsp_Error_Out, e_e);
        check({tag, "_acc"}, bus.Acc_Out, e_acc);
        check1({tag, "_busy"}, bus.Busy_Out, 1'b1);
        check1({tag, "_cmd_ready"}, bus.Cmd_Ready_Out, 1'b0);
        $display("cmd %s op=%h A=%h B=%h -> result=%h carry=%b zero=%b err=%b acc=%h lat=%0d",
                 tag, e_op, e_a, e_b, bus.Rsp_Result_Out, bus.Rsp_Carry_Out,
                 bus.Rsp_Zero_Out, bus.Rsp_Error_Out, bus.Acc_Out, edges);
    endtask

    // Hold the response for 'hold' cycles, then complete the handshake.
    task automatic release_rsp(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check1({tag, "_hold_valid"}, bus.Rsp_Valid_Out, 1'b1);
            check({tag, "_hold_result"}, bus.Rsp_Result_Out, e_res);
            check1({tag, "_hold_carry"}, bus.Rsp_Carry_Out, e_c);
            check1({tag, "_hold_error"}, bus.Rsp_Error_Out, e_e);
            check1({tag, "_hold_cmd_ready"}, bus.Cmd_Ready_Out, 1'b0);
            check1({tag, "_hold_alu_en"}, bus.ALU_Enable_Out, 1'b0);
            check({tag, "_hold_alu_a"}, bus.ALU_Data_A_Out, e_a);
            check({tag, "_hold_acc"}, bus.Acc_Out, e_acc);
        end
        bus.Rsp_Ready_In = 1'b1;
        @(posedge clk); #1;
        bus.Rsp_Ready_In = 1'b0;
        check1({tag, "_done_valid"}, bus.Rsp_Valid_Out, 1'b0);
        check1({tag, "_done_busy"}, bus.Busy_Out, 1'b0);
        check({tag, "_done_acc"}, bus.Acc_Out, e_acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        rst_n              = 1'b0;
        bus.Cmd_Valid_In   = 1'b0;
        bus.Cmd_Op_In      = 4'h0;
        bus.Cmd_Use_Acc_In = 1'b0;
        bus.Cmd_Data_A_In  = 32'd0;
        bus.Cmd_Data_B_In  = 32'd0;
        bus.Acc_Clear_In   = 1'b0;
        bus.Rsp_Ready_In   = 1'b0;
        m_acc              = 32'd0;
        #1;
        check_reset("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Add with carry-out and zero result
        issue(4'h2, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        await_rsp("t1");
        check({"t1_const_result"}, bus.Rsp_Result_Out, 32'd0);
        check1("t1_const_carry", bus.Rsp_Carry_Out, 1'b1);
        release_rsp("t1", 0);

        // Chain through the accumulator
        issue(4'h2, 1'b0, 32'd5, 32'd7, 1'b0);
        await_rsp("t3a");
        check("t3a_const", bus.Rsp_Result_Out, 32'd12);
        release_rsp("t3a", 0);
        issue(4'h5, 1'b1, 32'h1234_5678, 32'd3, 1'b0);
        await_rsp("t3b");
        check("t3b_const", bus.Rsp_Result_Out, 32'd36);
        release_rsp("t3b", 0);
        check("t3_acc_const", bus.Acc_Out, 32'd36);

        // Divide by zero: short path, accumulator untouched
        issue(4'h6, 1'b0, 32'd100, 32'd0, 1'b0);
        await_rsp("t2");
        release_rsp("t2", 0);
        check("t2_acc_const", bus.Acc_Out, 32'd36);

        // Logical op: carry forced low
        issue(4'hA, 1'b0, 32'd0, 32'd0, 1'b0);
        await_rsp("t4");
        check("t4_const", bus.Rsp_Result_Out, 32'hFFFF_FFFF);
        release_rsp("t4", 0);

        // Accumulator clear on its own, then clear coinciding with a Use_Acc accept
        bus.Acc_Clear_In = 1'b1;
        @(posedge clk); #1;
        bus.Acc_Clear_In = 1'b0;
        m_acc = 32'd0;
        check("clr_acc", bus.Acc_Out, 32'd0);
        issue(4'h2, 1'b0, 32'd40, 32'd2, 1'b0);
        await_rsp("clr_a");
        release_rsp("clr_a", 0);
        issue(4'h2, 1'b1, 32'd999, 32'd5, 1'b1);
        await_rsp("clr_b");
        check("clr_b_const", bus.Rsp_Result_Out, 32'd5);
        release_rsp("clr_b", 0);

        // Backpressure with a pending command and a clear request while busy
        issue(4'h3, 1'b0, 32'd20, 32'd5, 1'b0);
        await_rsp("t5a");
        bus.Cmd_Valid_In   = 1'b1;
        bus.Cmd_Op_In      = 4'h1;
        bus.Cmd_Use_Acc_In = 1'b1;
        bus.Cmd_Data_A_In  = 32'd777;
        bus.Cmd_Data_B_In  = 32'd0;
        bus.Acc_Clear_In   = 1'b1;
        release_rsp("t5a", 5);
        check1("t5_idle_ready", bus.Cmd_Ready_Out, 1'b1);
        issue(4'h1, 1'b1, 32'd777, 32'd0, 1'b0);
        await_rsp("t5b");
        check("t5b_const", bus.Rsp_Result_Out, 32'd14);
        release_rsp("t5b", 0);

        // Reset during DRIVE aborts the command
        issue(4'h3, 1'b0, 32'd50, 32'd8, 1'b0);
        @(posedge clk); #1;
        bus.Cmd_Valid_In = 1'b0;
        check1("t6_drive_en", bus.ALU_Enable_Out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("t6");
        m_acc = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check1("t6_no_rsp", bus.Rsp_Valid_Out, 1'b0);
        end
        issue(4'h0, 1'b0, 32'd9, 32'd0, 1'b0);
        await_rsp("t6b");
        check("t6b_const", bus.Rsp_Result_Out, 32'd10);
        release_rsp("t6b", 0);

        // Random commands
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20));
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            issue(rop, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 7) == 0));
            await_rsp("rnd");
            release_rsp("rnd", $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
